// File: rtl/periph_bus_arbiter.sv
// Shares the peripheral register bus between the core (always wins) and a debug requester
// that uses the core's free Q-slot. Optional write guard on the SFR window: PERIPH_ARB_GUARD_EN.
module periph_bus_arbiter #(
    parameter logic [1:0] DBG_SLOT = 2'd0,
    parameter int         TIMEOUT  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] core_q,
    input  logic [8:0] core_addr,
    input  logic       core_wr_en,
    input  logic [7:0] core_wdata,
    output logic [7:0] core_rdata,
    output logic [8:0] bus_addr,
    output logic       bus_wr_en,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    input  logic       dbg_req,
    input  logic       dbg_we,
    input  logic [8:0] dbg_addr,
    input  logic [7:0] dbg_wdata,
    output logic       dbg_busy,
    output logic       dbg_grant,
    output logic       dbg_ack,
    output logic       dbg_err,
    output logic [7:0] dbg_rdata
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_ERR
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic          cap_we;
    logic [8:0]    cap_addr;
    logic [7:0]    cap_wdata;
    logic          slot_free;
    logic          timed_out;
    logic          capture;
    logic          guard_reject;

    assign core_rdata = bus_rdata;
    assign slot_free  = (core_q == DBG_SLOT) && !core_wr_en;
    assign timed_out  = (wait_cnt == CW'(TIMEOUT - 1));
    assign capture    = (state == ST_IDLE) && dbg_req;

`ifdef PERIPH_ARB_GUARD_EN
    // Debug writes into the core SFR window (any bank) would corrupt core state.
    assign guard_reject = dbg_we && (dbg_addr[6:0] < 7'h0C);
`else
    assign guard_reject = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dbg_busy   = 1'b0;
        dbg_grant  = 1'b0;
        dbg_ack    = 1'b0;
        dbg_err    = 1'b0;
        bus_addr   = core_addr;
        bus_wr_en  = core_wr_en;
        bus_wdata  = core_wdata;
        case (state)
            ST_IDLE: begin
                if (dbg_req) begin
                    state_next = guard_reject ? ST_ERR : ST_WAIT;
                end
            end
            ST_WAIT: begin
                dbg_busy = 1'b1;
                // The granting WAIT cycle is the access cycle itself; a free slot beats the timeout.
                if (slot_free) begin
                    dbg_grant  = 1'b1;
                    bus_addr   = cap_addr;
                    bus_wr_en  = cap_we;
                    bus_wdata  = cap_wdata;
                    state_next = ST_ACK;
                end else if (timed_out) begin
                    state_next = ST_ERR;
                end
            end
            ST_ACK: begin
                dbg_busy   = 1'b1;
                dbg_ack    = 1'b1;
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                dbg_busy   = 1'b1;
                dbg_err    = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_we    <= 1'b0;
            cap_addr  <= 9'd0;
            cap_wdata <= 8'd0;
            wait_cnt  <= '0;
            dbg_rdata <= 8'd0;
        end else begin
            if (capture) begin
                cap_we    <= dbg_we;
                cap_addr  <= dbg_addr;
                cap_wdata <= dbg_wdata;
                wait_cnt  <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (dbg_grant && !cap_we) begin
                dbg_rdata <= bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter; debug responses are queued at request time
// and checked when ack/err appears. Honours PERIPH_ARB_GUARD_EN like the design.
module tb_periph_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] core_q;
    logic [8:0] core_addr;
    logic       core_wr_en;
    logic [7:0] core_wdata;
    logic [7:0] core_rdata;
    logic [8:0] bus_addr;
    logic       bus_wr_en;
    logic [7:0] bus_wdata;
    logic [7:0] bus_rdata;
    logic       dbg_req;
    logic       dbg_we;
    logic [8:0] dbg_addr;
    logic [7:0] dbg_wdata;
    logic       dbg_busy;
    logic       dbg_grant;
    logic       dbg_ack;
    logic       dbg_err;
    logic [7:0] dbg_rdata;

    typedef struct packed {
        logic       is_err;
        logic [7:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    logic q_run = 1'b0;
    logic wr_pattern = 1'b0;
    logic [7:0] last_rdata = 8'h00;

    periph_bus_arbiter #(.DBG_SLOT(2'd0), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .core_q(core_q), .core_addr(core_addr),
        .core_wr_en(core_wr_en), .core_wdata(core_wdata), .core_rdata(core_rdata),
        .bus_addr(bus_addr), .bus_wr_en(bus_wr_en), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .dbg_req(dbg_req), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_busy(dbg_busy),
        .dbg_grant(dbg_grant), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
        .dbg_rdata(dbg_rdata)
    );

    always #5 clk = ~clk;

    // Response monitor: every ack/err must match the oldest queued expectation.
    always @(negedge clk) begin
        if (dbg_ack || dbg_err) begin
            exp_t e;
            tests++;
            if (dbg_ack && dbg_err) begin
                fails++;
                $display("[TB] FAIL resp_exclusive ack=%0b err=%0b required one of them", dbg_ack, dbg_err);
            end else if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL resp_unexpected ack=%0b err=%0b required no response", dbg_ack, dbg_err);
            end else begin
                e = exp_q.pop_front();
                if (dbg_err !== e.is_err || (dbg_ack && dbg_rdata !== e.rdata)) begin
                    fails++;
                    $display("[TB] FAIL resp_value err=%0b rdata=%h required err=%0b rdata=%h",
                             dbg_err, dbg_rdata, e.is_err, e.rdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (q_run) core_q = core_q + 2'd1;
        if (wr_pattern) core_wr_en = (core_q != 2'd0);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        core_q = 2'd0; core_addr = 9'h011; core_wr_en = 1'b0; core_wdata = 8'h22;
        bus_rdata = 8'h00; dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 9'd0; dbg_wdata = 8'd0;
        #3;
        tests++;
        if ({dbg_busy, dbg_grant, dbg_ack, dbg_err} !== 4'b0000 || dbg_rdata !== 8'h00
            || bus_addr !== 9'h011 || bus_wdata !== 8'h22) begin
            fails++;
            $display("[TB] FAIL reset_state busy/grant/ack/err=%b rdata=%h bus_addr=%h required 0000 00 011",
                     {dbg_busy, dbg_grant, dbg_ack, dbg_err}, dbg_rdata, bus_addr);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read();
        q_run = 1'b1;
        core_q = 2'd1; core_addr = 9'h0AA; bus_rdata = 8'hA5;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h005;
        exp_q.push_back('{is_err: 1'b0, rdata: 8'hA5});
        last_rdata = 8'hA5;
        for (int k = 1; k <= 5; k++) begin
            tick();
            dbg_req = 1'b0;
            tests++;
            if (dbg_busy !== (k <= 4) || dbg_grant !== (k == 3)
                || bus_addr !== ((k == 3) ? 9'h005 : 9'h0AA) || bus_wr_en !== 1'b0) begin
                fails++;
                $display("[TB] FAIL read_cycle%0d busy=%0b grant=%0b addr=%h required busy=%0b grant=%0b",
                         k, dbg_busy, dbg_grant, bus_addr, (k <= 4), (k == 3));
            end
        end
        bus_rdata = 8'h11;
        #1;
        tests++;
        if (dbg_rdata !== 8'hA5 || core_rdata !== 8'h11) begin
            fails++;
            $display("[TB] FAIL read_hold dbg_rdata=%h core_rdata=%h required a5 11", dbg_rdata, core_rdata);
        end
    endtask

    task automatic test_write();
        int dbg_writes = 0;
        q_run = 1'b1; wr_pattern = 1'b1;
        core_q = 2'd2; core_wr_en = 1'b1; core_addr = 9'h1F0; core_wdata = 8'h42;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h086; dbg_wdata = 8'h3C;
        exp_q.push_back('{is_err: 1'b0, rdata: last_rdata});
        for (int k = 1; k <= 4; k++) begin
            tick();
            dbg_req = 1'b0;
            if (bus_wr_en && bus_addr == 9'h086 && bus_wdata == 8'h3C) dbg_writes++;
            tests++;
            if (k == 2) begin
                if (dbg_grant !== 1'b1 || bus_addr !== 9'h086 || bus_wdata !== 8'h3C || bus_wr_en !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL write_access grant=%0b addr=%h data=%h we=%0b required 1 086 3c 1",
                             dbg_grant, bus_addr, bus_wdata, bus_wr_en);
                end
            end else if (dbg_grant !== 1'b0 || bus_addr !== core_addr || bus_wdata !== core_wdata
                         || bus_wr_en !== core_wr_en) begin
                fails++;
                $display("[TB] FAIL write_passthru%0d addr=%h we=%0b required addr=%h we=%0b",
                         k, bus_addr, bus_wr_en, core_addr, core_wr_en);
            end
        end
        tests++;
        if (dbg_writes !== 1) begin
            fails++;
            $display("[TB] FAIL write_count got %0d required 1", dbg_writes);
        end
        wr_pattern = 1'b0; core_wr_en = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_busy [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic exp_gnt  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        q_run = 1'b1;
        core_q = 2'd3; core_addr = 9'h0BB; bus_rdata = 8'h3E;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h044;
        exp_q.push_back('{is_err: 1'b0, rdata: 8'h3E});
        exp_q.push_back('{is_err: 1'b0, rdata: 8'hC7});
        last_rdata = 8'hC7;
        #1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) tick();
            if (k == 2) bus_rdata = 8'hC7;
            if (k == 4) dbg_req = 1'b0;
            tests++;
            if (dbg_busy !== exp_busy[k] || dbg_grant !== exp_gnt[k]) begin
                fails++;
                $display("[TB] FAIL b2b_cycle%0d busy=%0b grant=%0b required busy=%0b grant=%0b",
                         k, dbg_busy, dbg_grant, exp_busy[k], exp_gnt[k]);
            end
        end
    endtask

    task automatic test_timeout();
        q_run = 1'b0;
        core_q = 2'd2; core_wr_en = 1'b0; core_addr = 9'h0CC;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h0F0; dbg_wdata = 8'h55;
        exp_q.push_back('{is_err: 1'b1, rdata: last_rdata});
        for (int k = 1; k <= 18; k++) begin
            tick();
            dbg_req = 1'b0;
            tests++;
            if (dbg_err !== (k == 17) || dbg_busy !== (k <= 17) || dbg_grant !== 1'b0
                || bus_wr_en !== 1'b0 || bus_addr !== 9'h0CC) begin
                fails++;
                $display("[TB] FAIL timeout_cycle%0d err=%0b busy=%0b grant=%0b we=%0b required err=%0b busy=%0b",
                         k, dbg_err, dbg_busy, dbg_grant, bus_wr_en, (k == 17), (k <= 17));
            end
        end
    endtask

    task automatic test_core_conflict();
        q_run = 1'b1;
        core_q = 2'd3; core_wr_en = 1'b0; core_addr = 9'h1AB; core_wdata = 8'h6D;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h090; dbg_wdata = 8'h81;
        exp_q.push_back('{is_err: 1'b0, rdata: last_rdata});
        for (int k = 1; k <= 7; k++) begin
            tick();
            dbg_req = 1'b0;
            core_wr_en = (k == 1);
            #1;
            tests++;
            if (dbg_grant !== (k == 5) || dbg_busy !== (k <= 6)
                || bus_addr !== ((k == 5) ? 9'h090 : 9'h1AB) || bus_wr_en !== (k == 1 || k == 5)
                || bus_wdata !== ((k == 5) ? 8'h81 : 8'h6D)) begin
                fails++;
                $display("[TB] FAIL conflict_cycle%0d grant=%0b busy=%0b addr=%h we=%0b required grant=%0b",
                         k, dbg_grant, dbg_busy, bus_addr, bus_wr_en, (k == 5));
            end
        end
        core_wr_en = 1'b0;
    endtask

    task automatic test_guard();
        q_run = 1'b1;
        core_q = 2'd3; core_wr_en = 1'b0; core_addr = 9'h0DD;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h103; dbg_wdata = 8'h99;
`ifdef PERIPH_ARB_GUARD_EN
        exp_q.push_back('{is_err: 1'b1, rdata: last_rdata});
        for (int k = 1; k <= 5; k++) begin
            tick();
            dbg_req = 1'b0;
            tests++;
            if (dbg_err !== (k == 1) || dbg_busy !== (k == 1) || dbg_grant !== 1'b0
                || bus_wr_en !== 1'b0 || bus_addr !== 9'h0DD) begin
                fails++;
                $display("[TB] FAIL guard_cycle%0d err=%0b busy=%0b grant=%0b we=%0b required err=%0b",
                         k, dbg_err, dbg_busy, dbg_grant, bus_wr_en, (k == 1));
            end
        end
`else
        exp_q.push_back('{is_err: 1'b0, rdata: last_rdata});
        for (int k = 1; k <= 4; k++) begin
            tick();
            dbg_req = 1'b0;
            tests++;
            if (dbg_grant !== (k == 1) || bus_wr_en !== (k == 1)
                || bus_addr !== ((k == 1) ? 9'h103 : 9'h0DD) || dbg_busy !== (k <= 2)) begin
                fails++;
                $display("[TB] FAIL noguard_cycle%0d grant=%0b we=%0b addr=%h required grant=%0b",
                         k, dbg_grant, bus_wr_en, bus_addr, (k == 1));
            end
        end
`endif
    endtask

    task automatic test_reset_mid();
        q_run = 1'b1;
        core_q = 2'd1; core_wr_en = 1'b0; core_addr = 9'h0EE;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h020;
        tick();
        dbg_req = 1'b0;
        rst_n = 1'b0;
        #1;
        last_rdata = 8'h00;
        tests++;
        if ({dbg_busy, dbg_grant, dbg_ack, dbg_err} !== 4'b0000 || dbg_rdata !== 8'h00 || bus_addr !== 9'h0EE) begin
            fails++;
            $display("[TB] FAIL midreset_state busy/grant/ack/err=%b rdata=%h addr=%h required 0000 00 0ee",
                     {dbg_busy, dbg_grant, dbg_ack, dbg_err}, dbg_rdata, bus_addr);
        end
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            tests++;
            if (dbg_busy !== 1'b0 || dbg_grant !== 1'b0) begin
                fails++;
                $display("[TB] FAIL midreset_after%0d busy=%0b grant=%0b required 0 0", k, dbg_busy, dbg_grant);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_timeout();
        test_core_conflict();
        test_guard();
        test_reset_mid();
        tick();
        tests++;
        if (exp_q.size() !== 0) begin
            fails++;
            $display("[TB] FAIL resp_missing outstanding=%0d required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
